// File: rtl/sampled_pfd.sv
// Sampled phase-frequency detector: synchronizes both divided clocks, runs an
// IDLE/UP/DN pump FSM, and reports signed phase error, cycle slips and lock.
module sampled_pfd #(
    parameter int ERR_W    = 12,
    parameter int LOCK_TOL = 4,
    parameter int LOCK_CNT = 16
) (
    input  logic                    clk_ref_12M,
    input  logic                    rst_n,
    input  logic                    clk_div_ref,
    input  logic                    clk_div_rf,
    output logic                    pump_up,
    output logic                    pump_dn,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    phase_err_valid,
    output logic                    cycle_slip,
    output logic                    locked
);
    localparam int CW = ERR_W - 1;
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] TOL     = CW'(LOCK_TOL);
    localparam logic [LW-1:0] LC_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LC_MAX  = LW'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DN = 2'd2} state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Magnitude is at most 2^(ERR_W-1)-1, so the negation can never overflow.
    function automatic logic signed [ERR_W-1:0] to_err(input logic [CW-1:0] mag, input logic neg);
        logic signed [ERR_W-1:0] p;
        p = {1'b0, mag};
        if (neg) begin
            return -p;
        end else begin
            return p;
        end
    endfunction

    logic [2:0]    ref_sync_r;
    logic [2:0]    rf_sync_r;
    logic          edge_ref_s;
    logic          edge_rf_s;
    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic [CW-1:0] mag_nx_s;
    logic          neg_nx_s;
    logic          valid_nx_s;
    logic          slip_nx_s;
    logic          in_tol_s;
    logic [LW-1:0] lc_r;

    // Two-flop synchronizers plus a history flop for rising-edge detection.
    always_ff @(posedge clk_ref_12M or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync_r <= 3'b000;
            rf_sync_r  <= 3'b000;
        end else begin
            ref_sync_r <= {ref_sync_r[1:0], clk_div_ref};
            rf_sync_r  <= {rf_sync_r[1:0], clk_div_rf};
        end
    end

    assign edge_ref_s = ref_sync_r[1] & ~ref_sync_r[2];
    assign edge_rf_s  = rf_sync_r[1] & ~rf_sync_r[2];
    assign in_tol_s   = (mag_nx_s <= TOL);

    // Next-state, error-counter and strobe decode for the pump FSM.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        mag_nx_s   = {CW{1'b0}};
        neg_nx_s   = 1'b0;
        valid_nx_s = 1'b0;
        slip_nx_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (edge_ref_s && !edge_rf_s) begin
                    state_nx_s = UP;
                    cnt_nx_s   = CNT_ONE;
                end else if (!edge_ref_s && edge_rf_s) begin
                    state_nx_s = DN;
                    cnt_nx_s   = CNT_ONE;
                end else if (edge_ref_s && edge_rf_s) begin
                    valid_nx_s = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            UP: begin
                if (edge_rf_s && !edge_ref_s) begin
                    state_nx_s = IDLE;
                    valid_nx_s = 1'b1;
                    mag_nx_s   = cnt_r;
                end else if (edge_ref_s && !edge_rf_s) begin
                    slip_nx_s = 1'b1;
                    cnt_nx_s  = sat_inc(cnt_r);
                end else if (edge_ref_s && edge_rf_s) begin
                    valid_nx_s = 1'b1;
                    mag_nx_s   = cnt_r;
                    cnt_nx_s   = CNT_ONE;
                end else begin
                    cnt_nx_s = sat_inc(cnt_r);
                end
            end
            DN: begin
                neg_nx_s = 1'b1;
                if (edge_ref_s && !edge_rf_s) begin
                    state_nx_s = IDLE;
                    valid_nx_s = 1'b1;
                    mag_nx_s   = cnt_r;
                end else if (edge_rf_s && !edge_ref_s) begin
                    slip_nx_s = 1'b1;
                    cnt_nx_s  = sat_inc(cnt_r);
                end else if (edge_ref_s && edge_rf_s) begin
                    valid_nx_s = 1'b1;
                    mag_nx_s   = cnt_r;
                    cnt_nx_s   = CNT_ONE;
                end else begin
                    cnt_nx_s = sat_inc(cnt_r);
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state, registered pump outputs, error result and strobes.
    always_ff @(posedge clk_ref_12M or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            cnt_r           <= {CW{1'b0}};
            pump_up         <= 1'b0;
            pump_dn         <= 1'b0;
            phase_err       <= {ERR_W{1'b0}};
            phase_err_valid <= 1'b0;
            cycle_slip      <= 1'b0;
        end else begin
            state_r         <= state_nx_s;
            cnt_r           <= cnt_nx_s;
            pump_up         <= (state_nx_s == UP);
            pump_dn         <= (state_nx_s == DN);
            phase_err_valid <= valid_nx_s;
            cycle_slip      <= slip_nx_s;
            if (valid_nx_s) begin
                phase_err <= to_err(mag_nx_s, neg_nx_s);
            end
        end
    end

    // Lock counter follows the strobes; locked trails it by one cycle.
    always_ff @(posedge clk_ref_12M or negedge rst_n) begin
        if (!rst_n) begin
            lc_r   <= {LW{1'b0}};
            locked <= 1'b0;
        end else begin
            if (slip_nx_s || (valid_nx_s && !in_tol_s)) begin
                lc_r <= {LW{1'b0}};
            end else if (valid_nx_s && (lc_r != LC_MAX)) begin
                lc_r <= lc_r + LC_ONE;
            end
            locked <= (lc_r == LC_MAX);
        end
    end

endmodule
